// File: rtl/sema_pkg.sv
// Shared types for the serial-in/parallel-out receiver: FSM state encoding and
// the bit-counter width helper.
package sema_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } state_t;

  // Counter must be able to hold the value SIZE itself.
  function automatic int cnt_width(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/sema_bit_cnt.sv
// Saturating data-bit counter: cleared at the start bit, advanced once per
// shifted bit; tc flags that the bit being shifted now is the last one.
module sema_bit_cnt
  import sema_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = cnt_width(SIZE);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CW'(SIZE))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CW'(SIZE - 1));

endmodule

// File: rtl/sema_sipo_rx.sv
// Strobed serial receiver: start bit, SIZE data bits LSB first, stop bit,
// delivered on a valid/ready output with frame-error and overrun reporting.
module sema_sipo_rx
  import sema_pkg::*;
#(
  parameter int SIZE = 8,
  parameter int SET  = 0
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            CE,
  input  logic            sdi,
  input  logic            ready,
  output logic [SIZE-1:0] data,
  output logic            valid,
  output logic            frame_err,
  output logic            overrun
);

  state_t          state_q, state_d;
  logic [SIZE-1:0] sr_q, sr_d;
  logic [SIZE-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  logic cnt_clr, cnt_en, shift_en, stop_good, stop_bad, bit_tc, load;

  sema_bit_cnt #(.SIZE(SIZE)) u_bit_cnt (
    .clk  (clk),
    .srst (Reset),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc   (bit_tc)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (CE) begin
      case (state_q)
        IDLE:    if (!sdi) state_d = SHIFT;
        SHIFT:   if (bit_tc) state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    shift_en  = 1'b0;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    if (CE) begin
      case (state_q)
        IDLE:  cnt_clr = !sdi;
        SHIFT: begin
          cnt_en   = 1'b1;
          shift_en = 1'b1;
        end
        STOP: begin
          stop_good = sdi;
          stop_bad  = !sdi;
        end
        default: ;
      endcase
    end
  end

  // A finished word is taken only if the output slot is free or being drained
  // in this same cycle; otherwise it is dropped and overrun latches.
  always_comb begin
    sr_d        = shift_en ? ((SIZE'(sdi) << (SIZE - 1)) | (sr_q >> 1)) : sr_q;
    load        = stop_good && (!valid_q || ready);
    data_d      = load ? sr_q : data_q;
    valid_d     = load || (valid_q && !ready);
    overrun_d   = overrun_q || (stop_good && valid_q && !ready);
    frame_err_d = stop_bad;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      sr_q        <= '0;
      data_q      <= SIZE'(SET);
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sema_sipo_rx.sv
// Scoreboard bench for sema_sipo_rx: the driver models delivery/drop rules per
// cycle and queues expected events; a negedge monitor pops and compares.
module tb_sema_sipo_rx;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       CE = 1'b0;
  logic       sdi = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun;

  sema_sipo_rx #(.SIZE(8), .SET(0)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .CE        (CE),
    .sdi       (sdi),
    .ready     (ready),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [7:0] d;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       mv = 1'b0;
  logic       mov = 1'b0;
  logic [7:0] md = 8'h00;
  int         rdy_mode = 0;
  bit         started = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic pick_rdy();
    if (rdy_mode == 2) return 1'($urandom_range(0, 1));
    return (rdy_mode == 1);
  endfunction

  // ev: 0 = no frame end, 1 = good stop sampled, 2 = bad stop sampled
  task automatic do_cycle(input logic ce_i, input logic sdi_i, input logic rdy_i,
                          input int ev, input logic [7:0] w);
    Reset = 1'b0;
    CE    = ce_i;
    sdi   = sdi_i;
    ready = rdy_i;
    @(posedge clk);
    if (ev == 1) begin
      if (!mv || rdy_i) begin
        exp_q.push_back('{1'b0, w});
        mv = 1'b1;
        md = w;
      end else begin
        mov = 1'b1;
      end
    end else begin
      if (mv && rdy_i) mv = 1'b0;
      if (ev == 2) exp_q.push_back('{1'b1, 8'h00});
    end
    #1;
  endtask

  task automatic send_bit(input logic b, input int ev, input logic [7:0] w, input int stop_rdy);
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'($urandom_range(0, 1)), pick_rdy(), 0, 8'h00);
    do_cycle(1'b1, b, (stop_rdy < 0) ? pick_rdy() : 1'(stop_rdy), ev, w);
  endtask

  task automatic send_frame(input logic [7:0] w, input logic stop_b, input int stop_rdy);
    send_bit(1'b0, 0, 8'h00, -1);
    for (int i = 0; i < 8; i++) send_bit(w[i], 0, 8'h00, -1);
    send_bit(stop_b, stop_b ? 1 : 2, w, stop_rdy);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1, 0, 8'h00, -1);
  endtask

  task automatic pulse_ready();
    do_cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1, 0, 8'h00);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    CE    = 1'($urandom_range(0, 1));
    sdi   = 1'($urandom_range(0, 1));
    ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    mv  = 1'b0;
    mov = 1'b0;
    md  = 8'h00;
    #1;
  endtask

  // Monitor: a new word is presented when valid is high and the previous
  // cycle either had no word or completed a handshake.
  logic pv = 1'b0;
  logic pr = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (started) begin
      if ((valid === 1'b1) && (!pv || pr)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got 0x%0h, expected none", data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("word_kind", 32'(mon_e.is_err), 32'd0);
          chk("rx_data", 32'(data), 32'(mon_e.d));
          $display("rx word 0x%02h (expected 0x%02h)", data, mon_e.d);
        end
      end
      if (frame_err === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame_err: got 1, expected 0");
        end else begin
          mon_e = exp_q.pop_front();
          chk("err_kind", 32'(mon_e.is_err), 32'd1);
          $display("rx frame error");
        end
      end
      chk("overrun_track", 32'(overrun), 32'(mov));
    end
    pv = (valid === 1'b1);
    pr = (ready === 1'b1);
  end

  initial begin
    do_reset();
    started = 1'b1;
    chk("reset_data", 32'(data), 32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_frame_err", 32'(frame_err), 32'h0);
    chk("reset_overrun", 32'(overrun), 32'h0);

    // 0xA5 held until ready
    rdy_mode = 0;
    send_frame(8'hA5, 1'b1, -1);
    chk("a5_valid", 32'(valid), 32'h1);
    chk("a5_data", 32'(data), 32'hA5);
    idle_bits(3);
    chk("a5_hold_valid", 32'(valid), 32'h1);
    chk("a5_hold_data", 32'(data), 32'hA5);
    pulse_ready();
    chk("a5_drained", 32'(valid), 32'h0);

    // bad stop bit
    send_frame(8'h3C, 1'b0, -1);
    chk("ferr_pulse", 32'(frame_err), 32'h1);
    chk("ferr_valid", 32'(valid), 32'h0);
    chk("ferr_data", 32'(data), 32'hA5);
    do_cycle(1'b0, 1'b1, 1'b0, 0, 8'h00);
    chk("ferr_one_cycle", 32'(frame_err), 32'h0);

    // overrun
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    chk("ovr_data", 32'(data), 32'h11);
    chk("ovr_flag", 32'(overrun), 32'h1);
    pulse_ready();
    chk("ovr_drained", 32'(valid), 32'h0);
    chk("ovr_sticky", 32'(overrun), 32'h1);
    do_reset();
    chk("ovr_reset_clear", 32'(overrun), 32'h0);

    // simultaneous drain and new word
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, 1);
    chk("swap_data", 32'(data), 32'h22);
    chk("swap_valid", 32'(valid), 32'h1);
    chk("swap_overrun", 32'(overrun), 32'h0);
    pulse_ready();

    // reset mid-frame
    send_bit(1'b0, 0, 8'h00, -1);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 0, 8'h00, -1);
    do_reset();
    chk("midrst_data", 32'(data), 32'h0);
    chk("midrst_valid", 32'(valid), 32'h0);
    send_frame(8'h5A, 1'b1, -1);
    chk("post_rst_data", 32'(data), 32'h5A);
    pulse_ready();

    // line noise only on CE=0 cycles
    idle_bits(8);
    chk("noise_valid", 32'(valid), 32'h0);
    chk("noise_data", 32'(data), 32'h5A);
    chk("noise_ferr", 32'(frame_err), 32'h0);
    send_frame(8'hC3, 1'b1, -1);
    chk("noise_next_data", 32'(data), 32'hC3);
    pulse_ready();

    // randomized traffic
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0), -1);
      if ($urandom_range(0, 2) == 0) idle_bits(1);
    end
    rdy_mode = 1;
    idle_bits(2);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    chk("final_valid", 32'(valid), 32'(mv));
    chk("final_data", 32'(data), 32'(md));
    chk("final_overrun", 32'(overrun), 32'(mov));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sema_sipo_rx.md
SEMA_SIPO_RX -- requirements
Module: sema_sipo_rx

Interface
REQ-001 SHALL have parameter SIZE, default 8, data word width in bits (1..32).
REQ-002 SHALL have parameter SET, default 0, value driven on data after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port CE  input  1  bit strobe; the line is sampled only on cycles with CE=1.
REQ-006 SHALL have port sdi  input  1  serial line; idles high.
REQ-007 SHALL have port ready  input  1  consumer accepts data when valid=1 and ready=1.
REQ-008 SHALL have port data  output  SIZE  last received word.
REQ-009 SHALL have port valid  output  1  data holds an unaccepted word.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun  output  1  sticky flag: a good frame was dropped.

Function
REQ-012 Frame format SHALL be: start bit 0, then SIZE data bits LSB first, then stop bit 1, one bit per CE=1 cycle.
REQ-013 SHALL use states IDLE, SHIFT, STOP; transitions occur only on CE=1 cycles, except for reset.
REQ-014 IDLE: sdi=0 on CE -> SHIFT with bit counter cleared; sdi=1 -> stay IDLE.
REQ-015 SHIFT: each CE shifts sdi into the shift register MSB end and increments the counter; after the SIZE-th bit -> STOP.
REQ-016 The bit counter SHALL be $clog2(SIZE+1) bits wide and SHALL never exceed SIZE.
REQ-017 STOP: sdi=1 on CE is a good frame; sdi=0 on CE asserts frame_err for exactly the next cycle and discards the word; both cases -> IDLE.
REQ-018 On a good frame, data and valid=1 SHALL update on the clock edge following the CE cycle that sampled the stop bit (latency 1).
REQ-019 valid SHALL hold, and data SHALL stay stable, until a cycle with ready=1; valid SHALL then clear on the next edge.
REQ-020 If a good frame completes while valid=1 and ready=0: the new word is dropped, data is unchanged, and overrun is set.
REQ-021 If a good frame completes in the same cycle as valid=1 and ready=1: the new word is loaded, valid stays 1, and overrun is unchanged.
REQ-022 overrun SHALL clear only on Reset.
REQ-023 CE=0 cycles SHALL leave the state, counter and shift register unchanged.
REQ-024 frame_err and a data load SHALL never occur in the same cycle.

Reset
REQ-025 Reset=1 at a clock edge SHALL force state=IDLE, counter=0, shift register=0, data=SET, valid=0, frame_err=0 and overrun=0, regardless of CE.
REQ-026 Reset mid-frame SHALL abandon the partial word; reception resumes only at the next start bit after Reset=0.

Structure
REQ-027 The state enum (IDLE, SHIFT, STOP) SHALL be defined in the shared package sema_pkg.
REQ-028 The bit counter SHALL be a separate sub-module sema_bit_cnt with clear, enable and terminal-count outputs.
REQ-029 Only data, valid, frame_err and overrun SHALL be registered outputs; the block SHALL contain no combinational path from input to output.

Verification (SIZE=8, SET=0, CE every 4th cycle unless stated)
REQ-030 Frame 0,1,0,1,0,0,1,0,1,1 with ready=0 -> data=0xA5 and valid=1 one cycle after the stop CE, held until ready=1, then valid=0.
REQ-031 Frame carrying 0x3C with stop bit 0 -> frame_err high for exactly 1 cycle, valid=0, data unchanged.
REQ-032 Receive 0x11 with ready=0, then 0x22 -> data=0x11, overrun=1; after ready pulse valid=0, overrun stays 1.
REQ-033 Receive 0x11, then hold ready=1 in the cycle 0x22 completes -> data=0x22, valid=1, overrun=0.
REQ-034 Reset=1 after 4 data bits, then a full 0x5A frame -> after Reset data=0 and valid=0; afterwards data=0x5A with no stale bits.
REQ-035 sdi toggles 0/1 only on CE=0 cycles while idle high on CE=1 cycles -> state remains IDLE and no output changes.
